// File: rtl/ram256x1d_reader_pkg.sv
// Shared types and constants for the ram256x1d_reader read-side sequencer.
package ram256x1d_reader_pkg;

  localparam int RAM_DEPTH  = 256;
  localparam int RAM_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/ram256x1d_reader_bit_packer.sv
// Serial-to-parallel packer for ram256x1d_reader. The word output already includes
// the bit on din, so the caller can capture a complete word on its last-bit edge.
// Bit order is selected by RAM256X1D_READER_MSB_FIRST_EN (default LSB-first).
module bit_packer #(
  parameter int WORD_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] sr_d;

  generate
    if (WORD_W == 1) begin : g_single
      assign sr_d = din;
    end else begin : g_shift
`ifdef RAM256X1D_READER_MSB_FIRST_EN
      // The first bit of a word enters at bit 0 and ends up in the MSB.
      assign sr_d = {sr_q[WORD_W-2:0], din};
`else
      // The first bit of a word enters at the MSB and ends up in bit 0.
      assign sr_d = {din, sr_q[WORD_W-1:1]};
`endif
    end
  endgenerate

  assign word = sr_d;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      sr_q <= '0;
    end else if (en) begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/ram256x1d_reader.sv
// Read-side sequencer for a 256x1 distributed RAM: walks DPRA, packs DPO bits into
// WORD_W-bit words and streams them out on M_DATA/M_VALID/M_READY.
// Optional RAM256X1D_READER_MSB_FIRST_EN puts the first sampled bit in the word MSB.
module ram256x1d_reader
  import ram256x1d_reader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [RAM_ADDR_W-1:0] BASE,
  input  logic [7:0]            LEN,
  output logic [RAM_ADDR_W-1:0] DPRA,
  input  logic                  DPO,
  output logic [WORD_W-1:0]     M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int              CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  state_e                state_q, state_d;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [8:0]            words_left_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [WORD_W-1:0]     m_data_q;
  logic [WORD_W-1:0]     packed_word;
  logic                  m_valid_q;
  logic                  done_q;

  logic start_acc, last_bit, slot_free, sample, load, xfer;

  // START is refused in the DONE cycle even though the FSM is already back in IDLE.
  assign start_acc = (state_q == IDLE) && START && !done_q;
  assign last_bit  = (bit_cnt_q == LAST_BIT);
  assign slot_free = !m_valid_q || M_READY;
  assign sample    = (state_q == FETCH) && (!last_bit || slot_free);
  assign load      = (state_q == FETCH) && last_bit && slot_free;
  assign xfer      = m_valid_q && M_READY;

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_acc) state_d = FETCH;
      FETCH:   if (load && (words_left_q == 9'd0)) state_d = DRAIN;
      DRAIN:   if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q       <= '0;
      words_left_q <= '0;
      bit_cnt_q    <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_q == DRAIN) && xfer;

      if (start_acc) begin
        addr_q       <= BASE;
        words_left_q <= {1'b0, LEN};
        bit_cnt_q    <= '0;
      end

      // Address wraps modulo 256 through natural overflow.
      if (sample) addr_q <= addr_q + RAM_ADDR_W'(1);

      if (load) begin
        bit_cnt_q <= '0;
        if (words_left_q != 9'd0) words_left_q <= words_left_q - 9'd1;
      end else if (sample) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end

      if (load) begin
        m_data_q  <= packed_word;
        m_valid_q <= 1'b1;
      end else if (xfer) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  bit_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (start_acc || load),
    .en   (sample),
    .din  (DPO),
    .word (packed_word)
  );

  assign DPRA    = addr_q;
  assign M_DATA  = m_data_q;
  assign M_VALID = m_valid_q;
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;

endmodule

// File: doc/ram256x1d_reader.md
# ram256x1d_reader

Read-side sequencer for a 256×1 distributed RAM with an asynchronous read port. It drives the RAM's read address (`DPRA`), samples its 1-bit data output (`DPO`) and packs consecutive bits into `WORD_W`-bit words. Words leave on a valid/ready stream. It sits beside the RAM primitive, opposite the write-side logic, and turns the bit-serial store into a word stream for downstream consumers.

## Interface
- `WORD_W`, default 8: bits per output word; legal range 1..32.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset; takes priority over every other input.
- `START` in 1: request a burst; sampled only in IDLE.
- `BASE` in 8: first RAM bit address; captured with `START`.
- `LEN` in 8: number of words minus 1 (1..256 words); captured with `START`.
- `DPRA` out 8: read address to the RAM.
- `DPO` in 1: asynchronous read data from the RAM at `DPRA`.
- `M_DATA` out `WORD_W`: packed output word.
- `M_VALID` out 1: `M_DATA` holds a word.
- `M_READY` in 1: downstream accepts the word.
- `BUSY` out 1: burst in progress.
- `DONE` out 1: one-cycle pulse when the last word of a burst is accepted.

## Operation
- States:
  - IDLE: waits for `START`.
  - FETCH: samples one bit per cycle.
  - DRAIN: all words packed; waits for the last handshake.
- IDLE → FETCH on `START`:
  - `addr` ← `BASE`; `words_left` ← `LEN` (9-bit internal counter); `bit_cnt` ← 0; `BUSY` ← 1.
- In FETCH, `DPRA` = `addr`, and `DPO` is sampled into the packer on each edge.
- Address increment: `addr` increments modulo 256 after each sampled bit. 255 wraps to 0 silently, within and across words.
- Normal bit: when `bit_cnt` < `WORD_W`-1, sample the bit and increment `bit_cnt`.
- Last bit of a word (`bit_cnt` = `WORD_W`-1):
  - When the output slot is free (`!M_VALID || M_READY`): sample the bit, load the completed word into `M_DATA`, set `M_VALID`, clear `bit_cnt`.
  - If `words_left` = 0, go to DRAIN; otherwise decrement `words_left`.
  - When the slot is not free: stall. No sample, `addr` and `bit_cnt` hold, and `DPRA` stays stable.
- Handshake: a transfer occurs on any edge with `M_VALID && M_READY`. `M_VALID` then clears unless a new word loads on the same edge. `M_DATA` is stable while `M_VALID && !M_READY`.
- Bit order (default): bit i of a word is the RAM bit at word start address + i (LSB-first).
- DRAIN → IDLE on the final handshake. On that edge, `DONE` pulses high for one cycle and `BUSY` clears.
- Ignored inputs:
  - `START` outside IDLE, including in the DONE cycle.
  - `M_READY` while `M_VALID` = 0.
- RAM writes during a burst: each bit reflects RAM content at its sample edge. No snapshot or coherence is provided.

## Timing
- Reset values: `DPRA`=0, `M_DATA`=0, `M_VALID`=0, `BUSY`=0, `DONE`=0, state IDLE.
- Reset mid-burst aborts the burst: pending word discarded, no `DONE`.
- `START` sampled at edge t → `BUSY` high after t. The first bit is sampled at edge t+1 and `M_VALID` goes high after edge t+`WORD_W`.
- Throughput: one word per `WORD_W` cycles with `M_READY` held high. There are no bubbles between words.
- Burst length with no stalls: last word valid after edge t+(LEN+1)·`WORD_W`. `DONE` is high in the cycle after the last handshake edge.
- The RAM read is combinational (`DPRA`→`DPO`) and must settle within one `CLK` period.

## Configuration
- `RAM256X1D_READER_MSB_FIRST_EN` undefined: LSB-first packing as above.
- `RAM256X1D_READER_MSB_FIRST_EN` defined: the first sampled bit of each word lands in `M_DATA[WORD_W-1]` and the last in bit 0. Timing, handshake and address sequence are unchanged.

## Structure
- Package `ram256x1d_reader_pkg` holds:
  - state enum (IDLE, FETCH, DRAIN);
  - `RAM_DEPTH`=256;
  - `RAM_ADDR_W`=8.
- Sub-module `bit_packer`: `WORD_W` shift register with a sample-enable input and a clear input. It carries the bit-order option and outputs the assembled word.
- The top level holds the FSM, address and word counters, and the output register.

## Test plan
- RAM INIT=256'h…A5C3, `WORD_W`=8, `BASE`=0, `LEN`=0, `M_READY`=1 → `DPRA` walks 0..7; `M_DATA`=8'hC3 valid after edge t+8; `DONE` pulses once.
- Wrap: `BASE`=8'hFC, `LEN`=1 → address sequence 252..255, 0..11; word0 = {INIT[3:0], INIT[255:252]}, word1 = INIT[11:4].
- Backpressure: `LEN`=3, `M_READY` held low for 20 cycles after the first valid word → `M_DATA` stable, `DPRA` frozen at the last-bit address of word1; after release, 4 words in order and no bit lost or duplicated.
- `START` pulsed again during FETCH with a different `BASE` → ignored; the original burst completes unchanged.
- `RST` asserted mid-word → next cycle all outputs at reset values; a new `START` reads correctly from its own `BASE`.
- With `RAM256X1D_READER_MSB_FIRST_EN` defined and INIT[7:0]=8'h01, `BASE`=0 → `M_DATA`=8'h80.
